// File: rtl/fifo_stream_pkg.sv
// Shared defaults and occupancy encoding for the FIFO read-side stream adapter.
package fifo_stream_pkg;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;
endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry register buffer: head is always the oldest word, tail holds the second.
module stream_skid_buffer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occupancy
);
    occ_state_t            state;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= push_data;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b11: head_q <= push_data;
                        2'b10: begin
                            tail_q <= push_data;
                            state  <= OCC_TWO;
                        end
                        2'b01: state <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) tail_q <= push_data;
                        else      state  <= OCC_ONE;
                    end
                end
                default: state <= OCC_EMPTY;
            endcase
        end
    end

    // A push into a full buffer without a simultaneous pop would lose a word.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && state == OCC_TWO))
        else $error("stream_skid_buffer overflow");

    assign valid     = (state != OCC_EMPTY);
    assign head_data = head_q;
    assign occupancy = state;
endmodule

// File: rtl/fifo_read_stream.sv
// Turns the FIFO registered-read port into a first-word-fall-through valid/ready stream.
module fifo_read_stream
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   read_clk,
    input  logic                   read_rst,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   fifo_read_enable,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    input  logic                   out_ready,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] word_count
);
    logic       inflight;
    logic       pop;
    logic [2:0] committed;
    logic [2:0] limit;

    assign pop = out_valid & out_ready;

    // occupancy + inflight - pop < 2, rearranged to avoid an unsigned subtraction.
    assign committed        = {1'b0, occupancy} + {2'b00, inflight};
    assign limit            = 3'd2 + {2'b00, pop};
    assign fifo_read_enable = !read_rst && !fifo_empty && (committed < limit);

    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            inflight   <= 1'b0;
            word_count <= '0;
        end else begin
            inflight <= fifo_read_enable;
            if (pop) word_count <= word_count + 1'b1;
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk       (read_clk),
        .rst       (read_rst),
        .push      (inflight),
        .push_data (fifo_read_data),
        .pop       (pop),
        .valid     (out_valid),
        .head_data (out_data),
        .occupancy (occupancy)
    );
endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream with a behavioural registered-read FIFO model.
module tb_fifo_read_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_read_data = 8'h00;
    logic        out_ready = 1'b0;

    logic        re, ov;
    logic [7:0]  od;
    logic [1:0]  occ;
    logic [15:0] wc;

    logic        re4, ov4;
    logic [7:0]  od4;
    logic [1:0]  occ4;
    logic [3:0]  wc4;

    logic [7:0]  mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          re_count = 0;
    int          empty_reads = 0;

    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fifo_read_stream #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) u_dut (
        .read_clk         (clk),
        .read_rst         (rst),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (re),
        .out_valid        (ov),
        .out_data         (od),
        .out_ready        (out_ready),
        .occupancy        (occ),
        .word_count       (wc)
    );

    fifo_read_stream #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) u_dut4 (
        .read_clk         (clk),
        .read_rst         (rst),
        .fifo_empty       (fifo_empty),
        .fifo_read_data   (fifo_read_data),
        .fifo_read_enable (re4),
        .out_valid        (ov4),
        .out_data         (od4),
        .out_ready        (out_ready),
        .occupancy        (occ4),
        .word_count       (wc4)
    );

    // FIFO model: registered read, flushed whenever the read domain is reset.
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (re) begin
            fifo_read_data <= mem[rd_ptr[9:0]];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (re) re_count <= re_count + 1;
        if (re && fifo_empty) empty_reads <= empty_reads + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int         rs;
        int         base;
        int         popped;
        int         cycles;
        logic       hold_pending;
        logic [7:0] hold_data;

        // Power-on reset state
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_count", 32'(wc), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: reset while words are buffered
        out_ready = 1'b1;
        push_word(8'hA0);
        repeat (3) @(negedge clk);
        chk("t1_pre_count", 32'(wc), 32'd1);
        out_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        repeat (5) @(negedge clk);
        chk("t1_pre_occ", 32'(occ), 32'd2);
        chk("t1_pre_data", 32'(od), 32'hA1);
        rst = 1'b1;
        #1;
        chk("t1_re", 32'(re), 32'd0);
        chk("t1_valid", 32'(ov), 32'd0);
        chk("t1_data", 32'(od), 32'd0);
        chk("t1_occ", 32'(occ), 32'd0);
        chk("t1_count", 32'(wc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_no_stale", 32'(ov), 32'd0);
        end
        chk("t1_post_count", 32'(wc), 32'd0);

        // Test 2: burst of 01..07 with out_ready held high
        reset_dut();
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) push_word(8'(i));
        @(negedge clk);
        chk("t2_fill", 32'(ov), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("t2_valid", 32'(ov), 32'd1);
            chk("t2_data", 32'(od), 32'(i));
        end
        @(negedge clk);
        chk("t2_drained", 32'(ov), 32'd0);
        chk("t2_count", 32'(wc), 32'd7);

        // Test 3: backpressure fills the buffer, then drains in order
        reset_dut();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        repeat (5) @(negedge clk);
        chk("t3_occ", 32'(occ), 32'd2);
        chk("t3_re", 32'(re), 32'd0);
        chk("t3_valid", 32'(ov), 32'd1);
        chk("t3_hold", 32'(od), 32'h01);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk("t3_valid_d", 32'(ov), 32'd1);
            chk("t3_data", 32'(od), 32'(i));
        end
        @(negedge clk);
        chk("t3_drained", 32'(ov), 32'd0);
        chk("t3_count", 32'(wc), 32'd5);

        // Test 4: single word, plus out_ready toggling while idle
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            out_ready = ~out_ready;
            @(negedge clk);
            chk("t4_idle_valid", 32'(ov), 32'd0);
        end
        chk("t4_idle_count", 32'(wc), 32'd0);
        rs = re_count;
        out_ready = 1'b1;
        push_word(8'h08);
        @(negedge clk);
        chk("t4_fill", 32'(ov), 32'd0);
        @(negedge clk);
        chk("t4_valid", 32'(ov), 32'd1);
        chk("t4_data", 32'(od), 32'h08);
        @(negedge clk);
        chk("t4_gone", 32'(ov), 32'd0);
        chk("t4_count", 32'(wc), 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_re_pulses", 32'(re_count - rs), 32'd1);

        // Test 5: 256 random words with random out_ready
        reset_dut();
        base = wr_ptr;
        for (int i = 0; i < 256; i++) push_word(8'($urandom_range(0, 255)));
        popped = 0;
        cycles = 0;
        hold_pending = 1'b0;
        hold_data = 8'h00;
        while (popped < 256 && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            chk("t5_occ_max", 32'(occ <= 2'd2), 32'd1);
            if (hold_pending) begin
                chk("t5_hold_valid", 32'(ov), 32'd1);
                chk("t5_hold_data", 32'(od), 32'(hold_data));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (ov && out_ready) begin
                chk("t5_order", 32'(od), 32'(mem[(base + popped) % 1024]));
                popped++;
                hold_pending = 1'b0;
            end else begin
                hold_pending = ov;
                hold_data = od;
            end
        end
        chk("t5_delivered", 32'(popped), 32'd256);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_count", 32'(wc), 32'd256);
        chk("t5_count4", 32'(wc4), 32'd0);

        // Test 6: 17 words wrap the 4-bit counter to 1
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(8'h10 + i));
        repeat (25) @(negedge clk);
        chk("t6_count16", 32'(wc), 32'd17);
        chk("t6_count4", 32'(wc4), 32'd1);
        chk("t6_valid4", 32'(ov4), 32'd0);
        chk("t6_occ4", 32'(occ4), 32'd0);
        chk("t6_re4", 32'(re4), 32'd0);
        chk("t6_data4", 32'(od4), 32'h20);

        chk("no_read_when_empty", 32'(empty_reads), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
